// File: rtl/stream_demux_2.sv
// Registered 1-to-2 stream demultiplexer: each beat is steered by in_sel into a
// one-entry holding register per output, with a per-output delivered-beat counter.

module stream_demux_2_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             free_o
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             del;

  assign del = (state_q == FULL) & ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (del) cnt_d = cnt_q + CNT_W'(1);
    // A load while draining keeps the slot FULL, giving bubble-free pass-through.
    if (load_i) begin
      data_d  = data_i;
      state_d = FULL;
    end else if (del) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);
  assign cnt_o   = cnt_q;
  assign free_o  = (state_q == EMPTY) | ready_i;
endmodule

module stream_demux_2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int NUM_OUT = 2;

  logic [NUM_OUT-1:0]            rdy_w, free_w, vld_w, load_w;
  logic [NUM_OUT-1:0][WIDTH-1:0] data_w;
  logic [NUM_OUT-1:0][CNT_W-1:0] cnt_w;

  assign rdy_w    = {out1_ready, out0_ready};
  // in_ready looks only at the selected slot, so a stalled output never blocks the other.
  assign in_ready = free_w[in_sel];

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign load_w[k] = in_valid & in_ready & (in_sel == 1'(k));

    stream_demux_2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_w[k]),
      .data_i  (in_data),
      .ready_i (rdy_w[k]),
      .data_o  (data_w[k]),
      .valid_o (vld_w[k]),
      .cnt_o   (cnt_w[k]),
      .free_o  (free_w[k])
    );
  end

  assign out0_data  = data_w[0];
  assign out1_data  = data_w[1];
  assign out0_valid = vld_w[0];
  assign out1_valid = vld_w[1];
  assign cnt0       = cnt_w[0];
  assign cnt1       = cnt_w[1];
endmodule

// File: tb/tb_stream_demux_2.sv
// Directed bench for stream_demux_2: reset, routing, backpressure isolation,
// full-rate pass-through, counter wrap and reset mid-transfer.

module tb_stream_demux_2;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  stream_demux_2 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset held two edges while a beat is offered
    tick(); tick();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_out0_data", out0_data, 0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst_in_ready", in_ready, 1);

    // Basic routing
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 1'b0; #1;
    chk("route_in_ready", in_ready, 1);
    tick();
    chk("route_out0_valid", out0_valid, 1);
    chk("route_out0_data", out0_data, 8'hA5);
    in_data = 8'h3C; in_sel = 1'b1;
    tick();
    chk("route_out1_valid", out1_valid, 1);
    chk("route_out1_data", out1_data, 8'h3C);
    chk("route_out0_drained", out0_valid, 0);
    chk("route_cnt0", cnt0, 1);
    in_valid = 1'b0;
    tick();
    chk("route_cnt1", cnt1, 1);
    chk("route_out1_drained", out1_valid, 0);

    // Backpressure isolation
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b0;
    tick();
    chk("bp_out0_data_11", out0_data, 8'h11);
    in_data = 8'h22; #1;
    chk("bp_in_ready_low", in_ready, 0);
    tick();
    chk("bp_hold_valid", out0_valid, 1);
    chk("bp_hold_data", out0_data, 8'h11);
    chk("bp_in_ready_still_low", in_ready, 0);
    out0_ready = 1'b1; #1;
    chk("bp_in_ready_release", in_ready, 1);
    tick();
    chk("bp_cnt0_after_11", cnt0, 2);
    chk("bp_out0_data_22", out0_data, 8'h22);
    out0_ready = 1'b0; in_data = 8'h33; in_sel = 1'b1; #1;
    chk("bp_other_in_ready", in_ready, 1);
    tick();
    chk("bp_out1_data_33", out1_data, 8'h33);
    chk("bp_out1_valid", out1_valid, 1);
    chk("bp_out0_still_22", out0_data, 8'h22);
    in_valid = 1'b0;
    tick();
    chk("bp_cnt1_after_33", cnt1, 2);
    chk("bp_out0_still_valid", out0_valid, 1);
    chk("bp_cnt0_stalled", cnt0, 2);
    out0_ready = 1'b1;
    tick();
    chk("bp_cnt0_after_22", cnt0, 3);
    chk("bp_out0_empty", out0_valid, 0);

    // Full-rate pass-through on out1
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_sel = 1'b1; #1;
      chk("fr_in_ready", in_ready, 1);
      tick();
      chk("fr_out1_valid", out1_valid, 1);
      chk("fr_out1_data", out1_data, i);
      chk("fr_cnt1", cnt1, 2 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("fr_cnt1_final", cnt1, 18);
    chk("fr_out1_empty", out1_valid, 0);

    // Counter wrap: 257 more beats on out0 (3 + 257 = 260 -> 4 mod 256)
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_sel = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt0", cnt0, 4);
    chk("wrap_cnt1", cnt1, 18);
    chk("wrap_last_data", out0_data, 8'h00);

    // Reset with out0 holding an undelivered beat
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; in_sel = 1'b0;
    tick();
    chk("mid_out0_valid", out0_valid, 1);
    chk("mid_out0_data", out0_data, 8'h77);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_out0_cleared", out0_valid, 0);
    chk("mid_cnt0", cnt0, 0);
    chk("mid_cnt1", cnt1, 0);
    chk("mid_out0_data", out0_data, 0);
    out0_ready = 1'b1;
    tick();
    chk("mid_no_delivery", cnt0, 0);
    chk("mid_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_demux_2.md
# stream_demux_2

Registered 1-to-2 stream demultiplexer: the dispatch-side counterpart of the team's 2:1 select mux. Accepts one valid/ready input stream, routes each beat to output 0 or output 1 according to a per-beat select bit, and holds it in a one-entry register per output until that output's consumer takes it. Per-output transfer counters support debug and bench checking.

## Interface
- WIDTH, 8, data width of every stream
- CNT_W, 8, width of each per-output delivered-beat counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  input beat payload
- in_sel  in  1  destination of current input beat (0 → out0, 1 → out1)
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts input beat this cycle
- out0_data / out1_data  out  WIDTH  registered payload per output
- out0_valid / out1_valid  out  1  output register holds a beat
- out0_ready / out1_ready  in  1  consumer takes beat this cycle
- cnt0 / cnt1  out  CNT_W  beats delivered on out0 / out1 (modulo 2^CNT_W)

## Operation
- Per output k: one holding register (data_k, valid_k). Two states per output: EMPTY (valid_k=0), FULL (valid_k=1).
- Input accept: acc = in_valid & in_ready. in_ready is combinational: in_sel=0 → (~out0_valid | out0_ready); in_sel=1 → (~out1_valid | out1_ready). in_ready may be high while in_valid low.
- Output deliver: del_k = outk_valid & outk_ready.
- Register k update each edge:
  - acc to k and del_k: load in_data, stay FULL (pass-through, no bubble).
  - acc to k only: load in_data, EMPTY→FULL.
  - del_k only: FULL→EMPTY; data_k holds last value (don't-care).
  - neither: hold.
- Beat routed to k never touches register of the other output; the other output drains independently in the same cycle.
- Ordering: beats to the same output stay in order; no ordering guarantee across outputs.
- outk_data stable while outk_valid=1 and outk_ready=0.
- Counters: cntk increments by 1 on every del_k; wraps from 2^CNT_W−1 to 0; never saturates.
- in_data and in_sel sampled only on acc; ignored otherwise.
- Producer rule: once in_valid asserted it holds in_valid, in_data, in_sel until acc (bench enforces; block does not check).

## Timing
- Reset (rst=1 at edge): out0_valid=0, out1_valid=0, cnt0=0, cnt1=0, out0_data=0, out1_data=0. in_ready during reset follows the combinational rule on post-reset state (i.e. 1 once registers clear). Reset mid-transfer discards any held beat; no delivery counted for it.
- Latency: beat accepted at edge N appears on outk_valid/outk_data immediately after edge N (visible in cycle N+1); earliest delivery at edge N+1.
- Throughput: 1 beat/cycle sustained to a single output with outk_ready held high; 1 beat/cycle alternating outputs.
- Backpressure: outk FULL and outk_ready=0 → in_ready=0 whenever in_sel=k; beats to the other output still flow.
- No combinational path from in_valid to any output; in_ready depends only on in_sel, outk_valid, outk_ready.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 → out0_valid=out1_valid=0, cnt0=cnt1=0; after release in_ready=1.
- Basic routing: send 0xA5 sel=0 then 0x3C sel=1, both readys=1 → out0 shows 0xA5 one cycle after accept, out1 shows 0x3C next cycle; cnt0=1, cnt1=1.
- Backpressure isolation: out0_ready=0, send 0x11 sel=0 then 0x22 sel=0 then 0x33 sel=1 → out0 holds 0x11, in_ready=0 for 0x22 until out0_ready=1; 0x33 delivered on out1 while out0 stalled.
- Full-rate pass-through: 16 consecutive beats 0x00..0x0F sel=1, out1_ready=1 → in_ready never drops, out1 delivers 0x00..0x0F in order on consecutive cycles, cnt1=16.
- Counter wrap (CNT_W=8): deliver 257 beats to out0 → cnt0=1; cnt1 unchanged.
- Reset mid-operation: out0 FULL with 0x77, out0_ready=0, assert rst → out0_valid=0 next cycle, cnt0=0, 0x77 never delivered.
